ram_port_arbiter: RTL and testbench

- Request arbiter that sits directly upstream of the 3-port (Left/Middle/Right) RAM cell matrix.
- Accepts independent read/write requests from three clients.
- Detects same-address hazards between ports and issues only non-conflicting accesses each cycle, using a rotating priority.
- Registers the matrix address, write-enable and data lines, and returns each read word to its client with a valid strobe.

---
 rtl/ram_port_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Front end for the 3-port (Left/Middle/Right) RAM cell matrix. Three clients
// issue independent read/write requests. Every request that does not hazard
// (same word, at least one writer) with a higher-priority grant is accepted in
// the same cycle. The priority pointer rotates L -> M -> R after any cycle that
// leaves a requester waiting. Granted accesses drive registered matrix lines.
// Read words come back on *_rdata with a one-cycle *_rvalid pulse, two cycles
// after the grant.
//
// Handshake: a client raises *_req with stable addr/we/wdata and holds them
// until it sees *_gnt high in the same cycle. The access is taken at that clock
// edge, and the client may change its inputs from then on. Dropping *_req
// before a grant withdraws the request. *_rvalid has no back-pressure.
module ram_port_arbiter #(
    parameter int N             = 16,
    parameter int no_addr_lines = 4,
    parameter int wordsize      = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     L_req,
    input  logic                     M_req,
    input  logic                     R_req,
    input  logic                     L_we,
    input  logic                     M_we,
    input  logic                     R_we,
    input  logic [no_addr_lines-1:0] L_addr,
    input  logic [no_addr_lines-1:0] M_addr,
    input  logic [no_addr_lines-1:0] R_addr,
    input  logic [wordsize-1:0]      L_wdata,
    input  logic [wordsize-1:0]      M_wdata,
    input  logic [wordsize-1:0]      R_wdata,
    output logic                     L_gnt,
    output logic                     M_gnt,
    output logic                     R_gnt,
    output logic [wordsize-1:0]      L_rdata,
    output logic [wordsize-1:0]      M_rdata,
    output logic [wordsize-1:0]      R_rdata,
    output logic                     L_rvalid,
    output logic                     M_rvalid,
    output logic                     R_rvalid,
    output logic [no_addr_lines-1:0] L_address,
    output logic [no_addr_lines-1:0] M_address,
    output logic [no_addr_lines-1:0] R_address,
    output logic                     Left_Write,
    output logic                     Middle_Write,
    output logic                     Right_Write,
    output logic [wordsize-1:0]      L_Data_Bit_Line,
    output logic [wordsize-1:0]      M_Data_Bit_Line,
    output logic [wordsize-1:0]      R_Data_Bit_Line,
    input  logic [wordsize-1:0]      L_Data_Bit_Line_read,
    input  logic [wordsize-1:0]      M_Data_Bit_Line_read,
    input  logic [wordsize-1:0]      R_Data_Bit_Line_read
);

    localparam int NP = 3;

    // The matrix depth must match the address width handed to it.
    if (N != (1 << no_addr_lines)) begin : g_bad_depth
        $error("ram_port_arbiter: N must equal 2**no_addr_lines");
    end

    typedef enum logic [1:0] {
        PRI_L = 2'd0,
        PRI_M = 2'd1,
        PRI_R = 2'd2
    } prio_e;

    // Port index 0 = L, 1 = M, 2 = R throughout.
    logic [NP-1:0]            req;
    logic [NP-1:0]            we;
    logic [no_addr_lines-1:0] addr    [NP];
    logic [wordsize-1:0]      wdata   [NP];
    logic [wordsize-1:0]      rd_line [NP];

    assign req        = {R_req, M_req, L_req};
    assign we         = {R_we, M_we, L_we};
    assign addr[0]    = L_addr;
    assign addr[1]    = M_addr;
    assign addr[2]    = R_addr;
    assign wdata[0]   = L_wdata;
    assign wdata[1]   = M_wdata;
    assign wdata[2]   = R_wdata;
    assign rd_line[0] = L_Data_Bit_Line_read;
    assign rd_line[1] = M_Data_Bit_Line_read;
    assign rd_line[2] = R_Data_Bit_Line_read;

    logic [NP-1:0] conf [NP];
    prio_e         prio_q, prio_d;
    logic [1:0]    o0, o1, o2;
    logic [NP-1:0] g;
    logic          deny;

    // Pairwise hazard: both ports requesting the same word, at least one writing.
    always_comb begin
        for (int i = 0; i < NP; i++) begin
            conf[i] = '0;
            for (int j = 0; j < NP; j++) begin
                if (i != j) begin
                    conf[i][j] = req[i] & req[j] & (addr[i] == addr[j]) & (we[i] | we[j]);
                end
            end
        end
    end

    // Visit ports from the pointer; grant each unless it hazards with an earlier grant.
    always_comb begin
        o0 = 2'd0;
        o1 = 2'd1;
        o2 = 2'd2;
        case (prio_q)
            PRI_M: begin
                o0 = 2'd1;
                o1 = 2'd2;
                o2 = 2'd0;
            end
            PRI_R: begin
                o0 = 2'd2;
                o1 = 2'd0;
                o2 = 2'd1;
            end
            default: ;
        endcase
        g     = '0;
        g[o0] = req[o0];
        g[o1] = req[o1] & ~(g[o0] & conf[o1][o0]);
        g[o2] = req[o2] & ~(g[o0] & conf[o2][o0]) & ~(g[o1] & conf[o2][o1]);
        deny  = |(req & ~g);
        prio_d = prio_q;
        if (deny) begin
            case (prio_q)
                PRI_L:   prio_d = PRI_M;
                PRI_M:   prio_d = PRI_R;
                default: prio_d = PRI_L;
            endcase
        end
    end

    // Rotate priority after any cycle that left a requester waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= PRI_L;
        end else begin
            prio_q <= prio_d;
        end
    end

    logic [NP-1:0]            write_q;
    logic [NP-1:0]            rd_pend_q;
    logic [NP-1:0]            rvalid_q;
    logic [no_addr_lines-1:0] addr_q  [NP];
    logic [wordsize-1:0]      data_q  [NP];
    logic [wordsize-1:0]      rdata_q [NP];

    // Issue stage: launch granted accesses onto the matrix lines, hold lines when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_q   <= '0;
            rd_pend_q <= '0;
            for (int i = 0; i < NP; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            write_q   <= g & we;
            rd_pend_q <= g & ~we;
            for (int i = 0; i < NP; i++) begin
                if (g[i]) begin
                    addr_q[i] <= addr[i];
                    data_q[i] <= wdata[i];
                end
            end
        end
    end

    // Return stage: capture the matrix read word the cycle after issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= '0;
            for (int i = 0; i < NP; i++) begin
                rdata_q[i] <= '0;
            end
        end else begin
            rvalid_q <= rd_pend_q;
            for (int i = 0; i < NP; i++) begin
                if (rd_pend_q[i]) begin
                    rdata_q[i] <= rd_line[i];
                end
            end
        end
    end

    // Grants are held low while reset is asserted.
    assign L_gnt = g[0] & rst_n;
    assign M_gnt = g[1] & rst_n;
    assign R_gnt = g[2] & rst_n;

    assign L_address       = addr_q[0];
    assign M_address       = addr_q[1];
    assign R_address       = addr_q[2];
    assign Left_Write      = write_q[0];
    assign Middle_Write    = write_q[1];
    assign Right_Write     = write_q[2];
    assign L_Data_Bit_Line = data_q[0];
    assign M_Data_Bit_Line = data_q[1];
    assign R_Data_Bit_Line = data_q[2];
    assign L_rvalid        = rvalid_q[0];
    assign M_rvalid        = rvalid_q[1];
    assign R_rvalid        = rvalid_q[2];
    assign L_rdata         = rdata_q[0];
    assign M_rdata         = rdata_q[1];
    assign R_rdata         = rdata_q[2];

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter
// Directed scenarios followed by randomized client traffic. A behavioural
// 16-word matrix sits behind the arbiter. A transaction-level reference model
// decides grants from the rotation rules. It tracks the word contents as
// accesses are accepted and queues the expected read returns with their due
// cycle.
module tb_ram_port_arbiter;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int NW = 16;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- client inputs ----------------
  logic [2:0]    req = '0;
  logic [2:0]    we  = '0;
  logic [AW-1:0] addr  [3];
  logic [DW-1:0] wdata [3];

  // ---------------- DUT outputs ----------------
  logic          L_gnt, M_gnt, R_gnt;
  logic [DW-1:0] L_rdata, M_rdata, R_rdata;
  logic          L_rvalid, M_rvalid, R_rvalid;
  logic [AW-1:0] L_address, M_address, R_address;
  logic          Left_Write, Middle_Write, Right_Write;
  logic [DW-1:0] L_Data_Bit_Line, M_Data_Bit_Line, R_Data_Bit_Line;
  logic [DW-1:0] L_rd, M_rd, R_rd;

  ram_port_arbiter #(.N(NW), .no_addr_lines(AW), .wordsize(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .L_req(req[0]), .M_req(req[1]), .R_req(req[2]),
    .L_we(we[0]), .M_we(we[1]), .R_we(we[2]),
    .L_addr(addr[0]), .M_addr(addr[1]), .R_addr(addr[2]),
    .L_wdata(wdata[0]), .M_wdata(wdata[1]), .R_wdata(wdata[2]),
    .L_gnt(L_gnt), .M_gnt(M_gnt), .R_gnt(R_gnt),
    .L_rdata(L_rdata), .M_rdata(M_rdata), .R_rdata(R_rdata),
    .L_rvalid(L_rvalid), .M_rvalid(M_rvalid), .R_rvalid(R_rvalid),
    .L_address(L_address), .M_address(M_address), .R_address(R_address),
    .Left_Write(Left_Write), .Middle_Write(Middle_Write), .Right_Write(Right_Write),
    .L_Data_Bit_Line(L_Data_Bit_Line), .M_Data_Bit_Line(M_Data_Bit_Line),
    .R_Data_Bit_Line(R_Data_Bit_Line),
    .L_Data_Bit_Line_read(L_rd), .M_Data_Bit_Line_read(M_rd), .R_Data_Bit_Line_read(R_rd)
  );

  logic [2:0]    d_gnt, d_write, d_rvalid;
  logic [AW-1:0] d_addr  [3];
  logic [DW-1:0] d_data  [3];
  logic [DW-1:0] d_rdata [3];
  assign d_gnt      = {R_gnt, M_gnt, L_gnt};
  assign d_write    = {Right_Write, Middle_Write, Left_Write};
  assign d_rvalid   = {R_rvalid, M_rvalid, L_rvalid};
  assign d_addr[0]  = L_address;
  assign d_addr[1]  = M_address;
  assign d_addr[2]  = R_address;
  assign d_data[0]  = L_Data_Bit_Line;
  assign d_data[1]  = M_Data_Bit_Line;
  assign d_data[2]  = R_Data_Bit_Line;
  assign d_rdata[0] = L_rdata;
  assign d_rdata[1] = M_rdata;
  assign d_rdata[2] = R_rdata;

  // ---------------- behavioural 3-port matrix ----------------
  function automatic logic [DW-1:0] init_word(input int i);
    if (i == 5) return 8'h5A;
    return DW'(i * 37 + 11);
  endfunction

  logic [DW-1:0] mem [NW];
  assign L_rd = mem[L_address];
  assign M_rd = mem[M_address];
  assign R_rd = mem[R_address];

  initial begin
    for (int i = 0; i < NW; i++) mem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (Left_Write)   mem[L_address] <= L_Data_Bit_Line;
      if (Middle_Write) mem[M_address] <= M_Data_Bit_Line;
      if (Right_Write)  mem[R_address] <= R_Data_Bit_Line;
    end
  end

  // ---------------- reference model / scoreboard ----------------
  typedef struct packed {
    logic [31:0]   due;
    logic [1:0]    port;
    logic [DW-1:0] data;
  } rd_exp_t;

  rd_exp_t       exp_q[$];
  int            m_ptr;
  logic [DW-1:0] m_mem   [NW];
  logic [2:0]    m_gnt;
  logic [2:0]    m_write;
  logic [AW-1:0] m_addr  [3];
  logic [DW-1:0] m_data  [3];
  logic [DW-1:0] m_rdata [3];
  logic [2:0]    last_dgnt;

  int    tests_run = 0;
  int    fails     = 0;
  string phase     = "init";
  string pn [3]    = '{"L", "M", "R"};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s/%s: got 0x%0h expected 0x%0h", phase, tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr   = 0;
    m_gnt   = '0;
    m_write = '0;
    for (int p = 0; p < 3; p++) begin
      m_addr[p]  = '0;
      m_data[p]  = '0;
      m_rdata[p] = '0;
    end
    exp_q.delete();
  endtask

  // Accept requests for the current cycle from the rotation and hazard rules.
  task automatic model_arb();
    logic [2:0] g;
    int         p;
    bit         ok;
    g = '0;
    for (int k = 0; k < 3; k++) begin
      p = (m_ptr + k) % 3;
      if (req[p]) begin
        ok = 1'b1;
        for (int j = 0; j < 3; j++) begin
          if (g[j] && addr[j] == addr[p] && (we[j] || we[p])) ok = 1'b0;
        end
        g[p] = ok;
      end
    end
    m_gnt = g;
    for (int q = 0; q < 3; q++) begin
      m_write[q] = g[q] & we[q];
      if (g[q]) begin
        m_addr[q] = addr[q];
        m_data[q] = wdata[q];
        if (we[q]) m_mem[addr[q]] = wdata[q];
        else exp_q.push_back('{due: 32'(cyc + 2), port: 2'(q), data: m_mem[addr[q]]});
      end
    end
    if ((req & ~g) != 3'b000) m_ptr = (m_ptr + 1) % 3;
  endtask

  task automatic check_regs();
    logic [2:0] exp_rv;
    rd_exp_t    e;
    exp_rv = '0;
    while (exp_q.size() > 0 && exp_q[0].due == 32'(cyc)) begin
      e = exp_q.pop_front();
      exp_rv[e.port]    = 1'b1;
      m_rdata[e.port]   = e.data;
    end
    for (int p = 0; p < 3; p++) begin
      chk($sformatf("%s_write", pn[p]), 32'(d_write[p]), 32'(m_write[p]));
      chk($sformatf("%s_address", pn[p]), 32'(d_addr[p]), 32'(m_addr[p]));
      chk($sformatf("%s_dataline", pn[p]), 32'(d_data[p]), 32'(m_data[p]));
      chk($sformatf("%s_rvalid", pn[p]), 32'(d_rvalid[p]), 32'(exp_rv[p]));
      chk($sformatf("%s_rdata", pn[p]), 32'(d_rdata[p]), 32'(m_rdata[p]));
    end
  endtask

  // One clock cycle: arbitrate and check grants mid-cycle, then check registered outputs.
  task automatic step();
    @(negedge clk);
    model_arb();
    last_dgnt = d_gnt;
    for (int p = 0; p < 3; p++) chk($sformatf("%s_gnt", pn[p]), 32'(d_gnt[p]), 32'(m_gnt[p]));
    @(posedge clk);
    #1;
    check_regs();
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_port(input int p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[p]   = 1'b1;
    we[p]    = w;
    addr[p]  = a;
    wdata[p] = d;
  endtask

  task automatic rand_clients();
    for (int p = 0; p < 3; p++) begin
      if (req[p] && !m_gnt[p]) begin
        if ($urandom_range(0, 7) == 0) req[p] = 1'b0;
      end else if ($urandom_range(0, 3) != 0) begin
        set_port(p, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, NW - 1)) : AW'($urandom_range(0, 3)),
                 DW'($urandom));
      end else begin
        req[p] = 1'b0;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int since [3];

  // ---------------- directed + random sequence ----------------
  initial begin
    for (int p = 0; p < 3; p++) begin
      addr[p]  = '0;
      wdata[p] = '0;
    end
    for (int i = 0; i < NW; i++) m_mem[i] = init_word(i);
    model_reset();

    // Power-on reset with requests pending: nothing granted, all lines zero.
    phase = "reset";
    req   = 3'b111;
    repeat (2) @(posedge clk);
    #1;
    for (int p = 0; p < 3; p++) chk($sformatf("%s_gnt", pn[p]), 32'(d_gnt[p]), 32'd0);
    check_regs();
    @(negedge clk);
    rst_n = 1'b1;
    req   = '0;
    @(posedge clk);
    #1;

    // 1: reset while a read is in flight; no rvalid may follow.
    phase = "t1";
    set_port(0, 1'b0, 4'd6, 8'h00);
    step();
    req   = '0;
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int p = 0; p < 3; p++) chk($sformatf("%s_gnt", pn[p]), 32'(d_gnt[p]), 32'd0);
    check_regs();
    #1;
    rst_n = 1'b1;
    repeat (3) step();

    // 4: three writes to word 2 held until granted; pointer starts at L.
    phase = "t4";
    set_port(0, 1'b1, 4'd2, 8'h11);
    set_port(1, 1'b1, 4'd2, 8'h22);
    set_port(2, 1'b1, 4'd2, 8'h33);
    step();
    chk("first_gnt", 32'(last_dgnt), 32'b001);
    req = req & ~m_gnt;
    step();
    chk("second_gnt", 32'(last_dgnt), 32'b010);
    req = req & ~m_gnt;
    step();
    chk("third_gnt", 32'(last_dgnt), 32'b100);
    req = req & ~m_gnt;
    repeat (2) step();
    chk("word2", 32'(mem[2]), 32'h33);

    // 2: two writes and a read to distinct words, all in one cycle.
    phase = "t2";
    set_port(0, 1'b1, 4'd3, 8'hA5);
    set_port(1, 1'b1, 4'd7, 8'h3C);
    set_port(2, 1'b0, 4'd9, 8'h00);
    step();
    chk("all_gnt", 32'(last_dgnt), 32'b111);
    req = '0;
    repeat (2) step();
    chk("word3", 32'(mem[3]), 32'hA5);
    chk("word7", 32'(mem[7]), 32'h3C);

    // 3: three reads of the same word share one cycle.
    phase = "t3";
    for (int p = 0; p < 3; p++) set_port(p, 1'b0, 4'd5, 8'h00);
    step();
    chk("all_gnt", 32'(last_dgnt), 32'b111);
    req = '0;
    step();
    chk("rvalid", 32'(d_rvalid), 32'b111);
    for (int p = 0; p < 3; p++) chk($sformatf("%s_word5", pn[p]), 32'(d_rdata[p]), 32'h5A);
    step();

    // 5: write then read of the same word on the next cycle.
    phase = "t5";
    set_port(0, 1'b1, 4'd4, 8'hF0);
    step();
    req[0] = 1'b0;
    set_port(1, 1'b0, 4'd4, 8'h00);
    step();
    chk("M_gnt", 32'(last_dgnt), 32'b010);
    req = '0;
    step();
    chk("M_rvalid", 32'(M_rvalid), 32'd1);
    chk("M_rdata", 32'(M_rdata), 32'hF0);
    step();

    // 6: permanent contention on word 1; each port served within any 3 cycles.
    phase = "t6";
    set_port(0, 1'b1, 4'd1, DW'($urandom));
    set_port(1, 1'b1, 4'd1, DW'($urandom));
    set_port(2, 1'b0, 4'd1, 8'h00);
    for (int p = 0; p < 3; p++) since[p] = 0;
    repeat (12) begin
      step();
      for (int p = 0; p < 3; p++) begin
        since[p] = last_dgnt[p] ? 0 : since[p] + 1;
        chk($sformatf("%s_served", pn[p]), 32'(since[p] <= 2), 32'd1);
        if (m_gnt[p]) wdata[p] = DW'($urandom);
      end
    end
    req = '0;
    repeat (2) step();

    // Random traffic over a small address window to provoke hazards.
    phase = "rand";
    repeat (400) begin
      step();
      rand_clients();
    end
    req = '0;
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
